// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: address/data words, byte strobes,
// the responder FSM states and the access-error check.
package mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam int MEM_WORD_BYTES = 4;

    typedef logic [MEM_WORD_BYTES-1:0] mem_strb_t;

    typedef enum logic [1:0] {
        MEM_RSP__IDLE,
        MEM_RSP__WAIT,
        MEM_RSP__RESP
    } mem_rsp_state_t;

    // An access is bad when it is not word aligned or falls past the backed storage.
    function automatic logic addr_err(input addr_t addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port synchronous RAM, 32-bit words with four byte-lane write enables.
// One read or one write per cycle; read data is registered. The array itself
// has no reset so it maps onto block RAM, one RAM column per byte lane.
module mem_byte_ram
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  data_t         wdata,
    input  mem_strb_t     wstrb,
    output data_t         rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < MEM_WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // Per-lane storage: write when this lane's strobe is set, otherwise register a read.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (wstrb[gi]) begin
                            lane_mem[addr] <= wdata[gi*8 +: 8];
                        end
                    end else begin
                        rd_byte_reg <= lane_mem[addr];
                    end
                end
            end

            assign rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory-side valid/ready responder with configurable access latency,
// byte-lane writes and error signalling. One transaction in flight at a time:
// accept in IDLE, count down in WAIT, commit to storage on the edge entering
// RESP, then hold the response until the initiator takes it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,      // active low: 0 holds the block in reset
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW           = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       SINGLE_CYCLE = (LATENCY == 1);

    mem_rsp_state_t state_reg, state_next;
    logic [3:0]     cnt_reg;

    // Captured request, used by the commit edge when it comes after the accept edge.
    addr_t          addr_reg;
    logic           we_reg;
    data_t          wdata_reg;
    mem_strb_t      wstrb_reg;
    logic           err_reg;

    // Response flags: rd_ok_reg gates the RAM output onto rsp_rdata.
    logic           rd_ok_reg;
    logic           rsp_err_reg;

    logic           accept;
    logic           commit;
    logic           handshake;

    // What the commit edge acts on: the live request when committing straight
    // from IDLE (LATENCY of 1), otherwise the captured copy.
    addr_t          c_addr;
    logic           c_we;
    data_t          c_wdata;
    mem_strb_t      c_wstrb;
    logic           c_err;

    data_t          ram_rdata;

    assign req_ready = (state_reg == MEM_RSP__IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign handshake = (state_reg == MEM_RSP__RESP) && rsp_ready;
    assign commit    = (state_reg == MEM_RSP__IDLE) ? (accept && SINGLE_CYCLE)
                                                    : ((state_reg == MEM_RSP__WAIT) && (cnt_reg == 4'd0));

    // Select live or captured request fields for the commit edge.
    always_comb begin
        c_addr  = addr_reg;
        c_we    = we_reg;
        c_wdata = wdata_reg;
        c_wstrb = wstrb_reg;
        c_err   = err_reg;
        if (state_reg == MEM_RSP__IDLE) begin
            c_addr  = req_addr;
            c_we    = req_we;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
            c_err   = addr_err(req_addr, DEPTH_WORDS);
        end
    end

    mem_byte_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (commit && !c_err),
        .we    (c_we),
        .addr  (c_addr[AW+1:2]),
        .wdata (c_wdata),
        .wstrb (c_wstrb),
        .rdata (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MEM_RSP__IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEM_RSP__IDLE: begin
                if (accept) begin
                    state_next = SINGLE_CYCLE ? MEM_RSP__RESP : MEM_RSP__WAIT;
                end
            end
            MEM_RSP__WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = MEM_RSP__RESP;
                end
            end
            MEM_RSP__RESP: begin
                if (rsp_ready) begin
                    state_next = MEM_RSP__IDLE;
                end
            end
            default: state_next = MEM_RSP__IDLE;
        endcase
    end

    // Latency counter and request capture at the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= CNT_INIT;
            addr_reg  <= req_addr;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
            err_reg   <= addr_err(req_addr, DEPTH_WORDS);
        end else if ((state_reg == MEM_RSP__WAIT) && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Response flags: set on the commit edge, cleared when the response is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ok_reg   <= 1'b0;
            rsp_err_reg <= 1'b0;
        end else if (commit) begin
            rd_ok_reg   <= !c_we && !c_err;
            rsp_err_reg <= c_err;
        end else if (handshake) begin
            rd_ok_reg   <= 1'b0;
            rsp_err_reg <= 1'b0;
        end
    end

    // The RAM output register only changes on a committed read, so masking it
    // with rd_ok_reg gives a stable, registered rsp_rdata that is 0 otherwise.
    assign rsp_valid = (state_reg == MEM_RSP__RESP);
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rd_ok_reg ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 2, 4 and 1)
// share one clock and reset; each transaction prints one line.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NDUT-1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0]     req_addr  [NDUT];
    logic [31:0]     req_wdata [NDUT];
    logic [31:0]     rsp_rdata [NDUT];
    logic [3:0]      req_wstrb [NDUT];

    int total = 0;
    int bad   = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            mem_responder #(
                .DEPTH_WORDS (1024),
                .LATENCY     ((gi == 0) ? 2 : ((gi == 1) ? 4 : 1))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_addr  (req_addr[gi]),
                .req_we    (req_we[gi]),
                .req_wdata (req_wdata[gi]),
                .req_wstrb (req_wstrb[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d; rsp_ready is held low for 'hold' cycles of RESP.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input int hold, input string tag);
        int n;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
        rsp_ready[d] = (hold == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat_of(d) - 1));
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        check({tag, " rdata"}, rsp_rdata[d], exp_rd);
        for (int i = 0; i < hold; i++) begin
            check({tag, " hold valid"}, 32'(rsp_valid[d]), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata[d], exp_rd);
            check({tag, " hold err"}, 32'(rsp_err[d]), 32'(exp_err));
            check({tag, " hold req_ready"}, 32'(req_ready[d]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        check({tag, " post valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, " post req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, " post rdata"}, rsp_rdata[d], 32'h0);
        rsp_ready[d] = 1'b0;
        $display("txn %-12s dut=%0d we=%0d addr=%h wdata=%h strb=%b -> err=%0d rdata=%h lat=%0d",
                 tag, d, we, addr, wdata, strb, exp_err, exp_rd, n + 1);
    endtask

    logic [31:0] b2b_exp [3];

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        for (int d = 0; d < NDUT; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wstrb[d] = '0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst req_ready", 32'(req_ready[d]), 32'd0);
            check("rst rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst rsp_err", 32'(rsp_err[d]), 32'd0);
            check("rst rsp_rdata", rsp_rdata[d], 32'h0);
        end
        reset = 1'b1;

        // Basic write then read, LATENCY 2.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0, 0, "wr10");
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 0, "rd10");

        // Byte lanes: lanes 0 and 2 replaced.
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0, 32'h0, 0, "wr20");
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 0, "wr20strb");
        txn(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 32'h11BB33DD, 0, "rd20");
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 0, "wr20none");
        txn(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 32'h11BB33DD, 0, "rd20again");

        // Errors: misaligned and out of range, storage untouched.
        txn(0, 1'b1, 32'h0, 32'h01020304, 4'b1111, 1'b0, 32'h0, 0, "wr0");
        txn(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0, 0, "wrlast");
        txn(0, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b1, 32'h0, 0, "rd13err");
        txn(0, 1'b1, 32'h1000, 32'h99999999, 4'b1111, 1'b1, 32'h0, 0, "wroorerr");
        txn(0, 1'b1, 32'h2, 32'h77777777, 4'b1111, 1'b1, 32'h0, 0, "wrmiserr");
        txn(0, 1'b0, 32'h1004, 32'h0, 4'b0000, 1'b1, 32'h0, 0, "rdoorerr");
        txn(0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h01020304, 0, "rd0");
        txn(0, 1'b0, 32'hFFC, 32'h0, 4'b0000, 1'b0, 32'hCAFEF00D, 0, "rdlast");

        // Backpressure: response held 5 cycles.
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 5, "rd10bp");

        // Reset mid-WAIT on the LATENCY 4 instance.
        txn(1, 1'b1, 32'h30, 32'h12345678, 4'b1111, 1'b0, 32'h0, 0, "wr30");
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h30;
        req_wdata[1] = 32'h55;
        req_wstrb[1] = 4'b1111;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rstwait in WAIT req_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstwait during rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rstwait during req_ready", 32'(req_ready[1]), 32'd0);
        reset = 1'b1;
        rsp_ready[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstwait after rsp_valid", 32'(rsp_valid[1]), 32'd0);
            check("rstwait after req_ready", 32'(req_ready[1]), 32'd1);
        end
        $display("txn %-12s dut=1 write 0x55 @30 dropped by reset", "rstwait");
        txn(1, 1'b0, 32'h30, 32'h0, 4'b0000, 1'b0, 32'h12345678, 0, "rd30");
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 0, "rd10keep");

        // LATENCY 1 back-to-back reads with req_valid held high.
        txn(2, 1'b1, 32'h40, 32'hA0A0A0A0, 4'b1111, 1'b0, 32'h0, 0, "wr40");
        txn(2, 1'b1, 32'h44, 32'h0B0B0B0B, 4'b1111, 1'b0, 32'h0, 0, "wr44");
        txn(2, 1'b1, 32'h48, 32'h0000C0DE, 4'b1111, 1'b0, 32'h0, 0, "wr48");
        b2b_exp[0] = 32'hA0A0A0A0;
        b2b_exp[1] = 32'h0B0B0B0B;
        b2b_exp[2] = 32'h0000C0DE;
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h40;
        rsp_ready[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                check("b2b rsp_valid", 32'(rsp_valid[2]), 32'd1);
                check("b2b rdata", rsp_rdata[2], b2b_exp[k/2]);
                check("b2b req_ready busy", 32'(req_ready[2]), 32'd0);
                $display("txn %-12s dut=2 read addr=%h rdata=%h", "b2b", req_addr[2], rsp_rdata[2]);
                req_addr[2] = req_addr[2] + 32'h4;
                if (k == 4) req_valid[2] = 1'b0;
            end else begin
                check("b2b rsp_valid gap", 32'(rsp_valid[2]), 32'd0);
                check("b2b req_ready gap", 32'(req_ready[2]), 32'd1);
            end
        end
        rsp_ready[2] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's load/store/fetch port. Replaces the zero-latency combinational memory with a valid/ready request/response slave that has configurable access latency, byte-lane writes and error signalling. One outstanding transaction at a time. The core-side initiator will later drive this port in place of the direct memory hookup.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words backed by storage (power of two, 16..65536)
LATENCY, 2, cycles from request acceptance edge to rsp_valid rising (legal 1..15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address
req_we  input  1  1 = write, 0 = read
req_wdata  input  32  write data
req_wstrb  input  4  byte-lane write enables, bit i -> bits 8i+7:8i
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- States: IDLE, WAIT, RESP. Reset (reset==0, any time) -> IDLE; counter=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; captured request cleared.
- req_ready = 1 only in IDLE and while reset is deasserted; 0 in WAIT and RESP.
- Accept: req_valid & req_ready at rising edge E0 latches addr/we/wdata/wstrb and computes err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
- LATENCY==1: E0 moves IDLE->RESP. Otherwise E0 moves IDLE->WAIT, counter=LATENCY-2; WAIT decrements each edge and moves to RESP at the edge where counter==0. rsp_valid therefore rises exactly after edge E0+LATENCY-1, i.e. it is visible LATENCY cycles after the accept cycle.
- On the edge entering RESP (the commit edge):
  - read, no err: rsp_rdata = mem[addr[31:2]].
  - write, no err: lanes with wstrb=1 are updated. rsp_rdata=0. wstrb=0000 is legal and is a no-op write.
  - err: no storage change, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready. At that edge: IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- req_ready returns the cycle after the response handshake. There is no same-cycle response-to-request overlap. Peak throughput is one transaction per LATENCY+1 cycles.
- req_valid in WAIT/RESP is ignored (not accepted). The initiator must hold it; no requirement on payload stability before acceptance.
- rsp_ready high while not in RESP has no effect.
- Reset mid-WAIT or mid-RESP drops the transaction with no response. A write already committed stays committed; a write not yet at its commit edge never lands. Storage contents are not cleared by reset.
- Storage reads are synchronous (registered into rsp_rdata), so no combinational path from req_* to rsp_*.

Decomposition:
- Shared types package gains: mem_rsp_state_t enum {MEM_RSP__IDLE, MEM_RSP__WAIT, MEM_RSP__RESP}; constant MEM_WORD_BYTES=4; typedef mem_strb_t (4-bit).
- Address/data use existing addr_t and data_t.
- One sub-module: mem_byte_ram, a single-port synchronous RAM with 4 byte-enables, one read-or-write per cycle, no reset on the array. The FSM, counter, error check and response registers stay in mem_responder.

Test Plan:
- LATENCY=2: write 0xDEADBEEF @0x10, strb 1111, rsp_ready=1 -> rsp_valid 2 cycles after accept, err=0, rdata=0. Then read @0x10 -> rdata=0xDEADBEEF 2 cycles after accept.
- Byte lanes: word @0x20=0x11223344, write 0xAABBCCDD strb 0101 -> read @0x20 returns 0x11BB33DD.
- Errors: read @0x13 -> rsp_err=1, rdata=0. Write @ DEPTH_WORDS*4 -> rsp_err=1. Storage checked unchanged by readback of word 0 and the last word.
- Backpressure: read @0x10 with rsp_ready=0 for 5 cycles -> rsp_valid/rdata/err stable all 5 cycles, req_ready=0 throughout. rsp_ready=1 -> rsp_valid 0 and req_ready 1 the next cycle.
- Reset mid-WAIT (LATENCY=4): write 0x55 @0x30, assert reset 1 cycle after accept -> rsp_valid never rises, req_ready=1 after release, read @0x30 returns old value.
- LATENCY=1 back-to-back with req_valid held high: 3 reads -> each rsp_valid appears 1 cycle after its accept; accepts spaced 2 cycles apart.
